// File: rtl/note_chart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_chart_pkg
// Brief    : Shared state encoding and chart entry sizing for the note chart
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package note_chart_pkg;

    localparam int c_default_lanes = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Each chart entry carries one bit per lane plus the END marker on top.
    function automatic int entry_width(input int lanes);
        return lanes + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_chart_if.sv
`default_nettype none
// ============================================================================
// Module   : note_chart_if
// Brief    : Control, chart-write and playback signals of the note chart
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface note_chart_if
    import note_chart_pkg::*;
#(
    parameter int LANES  = c_default_lanes,
    parameter int ADDR_W = 5
) ();

    logic                          start;
    logic                          pause;
    logic                          loop_en;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [entry_width(LANES)-1:0] wr_data;
    logic [LANES-1:0]              exp_notes;
    logic [ADDR_W-1:0]             step;
    logic                          beat;
    logic                          playing;
    logic                          done;

    modport master (
        output start, pause, loop_en, wr_en, wr_addr, wr_data,
        input  exp_notes, step, beat, playing, done
    );

    modport slave (
        input  start, pause, loop_en, wr_en, wr_addr, wr_data,
        output exp_notes, step, beat, playing, done
    );

endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Brief    : Counts CLK_PER_TICK enabled clocks per tick and flags the last.
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int CLK_PER_TICK = 13500000,
    parameter int CNT_W        = 24
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick_hit
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CLK_PER_TICK - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick_hit = en && (r_cnt == c_cnt_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick_hit ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_chart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_chart_sequencer
// Brief    : Plays a RAM-loaded note chart one step per tick, with restart,
//            pause, loop mode and END-marker handling.
// Revision : 1.0 - initial release
// ============================================================================
module note_chart_sequencer
    import note_chart_pkg::*;
#(
    parameter int LANES        = c_default_lanes,
    parameter int CHART_DEPTH  = 32,
    parameter int ADDR_W       = 5,
    parameter int CLK_PER_TICK = 13500000,
    parameter int CNT_W        = 24
) (
    input  wire logic   clk,
    input  wire logic   reset,
    note_chart_if.slave bus
);

    localparam int                c_entry_w   = entry_width(LANES);
    localparam logic [ADDR_W-1:0] c_last_step = ADDR_W'(CHART_DEPTH - 1);

    logic [c_entry_w-1:0] r_chart [CHART_DEPTH];
    logic [c_entry_w-1:0] r_rd_data;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_step,      w_step_nxt;
    logic [LANES-1:0]  r_exp_notes, w_notes_nxt;
    logic              r_last_flag, w_last_nxt;
    logic              r_beat,      w_beat_nxt;
    logic              w_tick_en;
    logic              w_tick_hit;
    logic              w_wrap;

    tick_divider #(
        .CLK_PER_TICK (CLK_PER_TICK),
        .CNT_W        (CNT_W)
    ) u_tick_divider (
        .clk      (clk),
        .reset    (reset),
        .en       (w_tick_en),
        .clr      (bus.start),
        .tick_hit (w_tick_hit)
    );

    assign w_tick_en = (r_state == ST_PLAY);

    // Chart storage survives reset; the read port lags the step by one cycle.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_chart[bus.wr_addr] <= bus.wr_data;
        end
        r_rd_data <= r_chart[r_step];
    end

    // The final physical entry acts as an implicit END marker.
    assign w_wrap = r_rd_data[LANES] || (r_step == c_last_step);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_notes_nxt = r_exp_notes;
        w_last_nxt  = r_last_flag;
        w_beat_nxt  = 1'b0;
        if (bus.start) begin
            w_step_nxt  = '0;
            w_notes_nxt = '0;
            w_last_nxt  = 1'b0;
            w_state_nxt = bus.pause ? ST_PAUSE : ST_PLAY;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_tick_hit) begin
                        w_beat_nxt = 1'b1;
                        if (r_last_flag && !bus.loop_en) begin
                            w_notes_nxt = '0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_notes_nxt = r_rd_data[LANES-1:0];
                            w_last_nxt  = w_wrap;
                            w_step_nxt  = w_wrap ? '0 : r_step + ADDR_W'(1);
                            if (bus.pause) w_state_nxt = ST_PAUSE;
                        end
                    end else if (bus.pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) w_state_nxt = ST_PLAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_exp_notes <= '0;
            r_last_flag <= 1'b0;
            r_beat      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_exp_notes <= w_notes_nxt;
            r_last_flag <= w_last_nxt;
            r_beat      <= w_beat_nxt;
        end
    end

    assign bus.exp_notes = r_exp_notes;
    assign bus.step      = r_step;
    assign bus.beat      = r_beat;
    assign bus.playing   = (r_state == ST_PLAY);
    assign bus.done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_note_chart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_chart_sequencer
// Brief    : Directed bench for note_chart_sequencer (5 lanes, 8 entries,
//            4 clocks per tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_chart_sequencer;

    localparam int c_lanes = 5;
    localparam int c_depth = 8;
    localparam int c_aw    = 3;
    localparam int c_cpt   = 4;

    typedef struct {
        logic       start;
        logic       pause;
        logic       loop_en;
        int         cycles;
        logic [4:0] notes;
        logic [2:0] step;
        logic       beat;
        logic       playing;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   r_checks = 0;
    int   r_fails  = 0;
    vec_t vecs[$];

    note_chart_if #(.LANES(c_lanes), .ADDR_W(c_aw)) bus ();

    note_chart_sequencer #(
        .LANES        (c_lanes),
        .CHART_DEPTH  (c_depth),
        .ADDR_W       (c_aw),
        .CLK_PER_TICK (c_cpt),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic wr(input int addr, input logic [5:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_data = data;
        run(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic v(input logic s, input logic p, input logic l, input int n,
                     input logic [4:0] nt, input logic [2:0] st,
                     input logic b, input logic pl, input logic d);
        vec_t e;
        e.start = s; e.pause = p; e.loop_en = l; e.cycles = n;
        e.notes = nt; e.step = st; e.beat = b; e.playing = pl; e.done = d;
        vecs.push_back(e);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] nt, input logic [2:0] st,
                           input logic b, input logic pl, input logic d);
        chk({tag, ".exp_notes"}, 32'(bus.exp_notes), 32'(nt));
        chk({tag, ".step"},      32'(bus.step),      32'(st));
        chk({tag, ".beat"},      32'(bus.beat),      32'(b));
        chk({tag, ".playing"},   32'(bus.playing),   32'(pl));
        chk({tag, ".done"},      32'(bus.done),      32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Three-step chart with END on entry 2
        v(1,0,0,1, 5'b00000,0,0,1,0);
        v(0,0,0,3, 5'b00000,0,0,1,0);
        v(0,0,0,1, 5'b00101,1,1,1,0);
        v(0,0,0,1, 5'b00101,1,0,1,0);
        v(0,0,0,3, 5'b01010,2,1,1,0);
        v(0,0,0,4, 5'b10100,0,1,1,0);
        v(0,0,0,4, 5'b00000,0,1,0,1);
        v(0,0,0,1, 5'b00000,0,0,0,1);
        v(0,0,0,4, 5'b00000,0,0,0,1);
        // Loop mode, restarted from DONE
        v(1,0,1,1, 5'b00000,0,0,1,0);
        v(0,0,1,4, 5'b00101,1,1,1,0);
        v(0,0,1,4, 5'b01010,2,1,1,0);
        v(0,0,1,4, 5'b10100,0,1,1,0);
        v(0,0,1,4, 5'b00101,1,1,1,0);
        v(0,0,1,4, 5'b01010,2,1,1,0);
        // Pause for cycles 6..11, restarted from PLAY
        v(1,0,0,1, 5'b00000,0,0,1,0);
        v(0,0,0,4, 5'b00101,1,1,1,0);
        v(0,0,0,1, 5'b00101,1,0,1,0);
        v(0,1,0,1, 5'b00101,1,0,0,0);
        v(0,1,0,5, 5'b00101,1,0,0,0);
        v(0,0,0,1, 5'b00101,1,0,1,0);
        v(0,0,0,1, 5'b00101,1,0,1,0);
        v(0,0,0,1, 5'b01010,2,1,1,0);

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(2);
        chk_out("reset", 5'b00000, 0, 0, 0, 0);

        wr(0, 6'b000101);
        wr(1, 6'b001010);
        wr(2, 6'b110100);
        chk_out("idle_after_load", 5'b00000, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start   = vecs[i].start;
            bus.pause   = vecs[i].pause;
            bus.loop_en = vecs[i].loop_en;
            run(vecs[i].cycles);
            chk_out($sformatf("row%0d", i), vecs[i].notes, vecs[i].step,
                    vecs[i].beat, vecs[i].playing, vecs[i].done);
        end

        // Full chart without END: wraps 7->0, stops on the 9th beat
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;
        for (int i = 0; i < c_depth; i++) wr(i, {1'b0, 5'(i + 1)});
        bus.start = 1'b1;
        run(1);
        for (int b = 1; b <= 9; b++) begin
            run(c_cpt);
            chk_out($sformatf("noend_beat%0d", b), (b <= 8) ? 5'(b) : 5'd0,
                    (b >= 8) ? 3'd0 : 3'(b), 1'b1, b != 9, b == 9);
        end

        // Asynchronous reset mid-play, chart retained
        bus.start = 1'b1;
        run(1);
        run(9);
        chk_out("pre_reset", 5'd2, 2, 0, 1, 0);
        reset = 1'b1;
        #1;
        chk_out("async_reset", 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b1;
        run(1);
        run(c_cpt);
        chk_out("replay_after_reset", 5'd1, 1, 1, 1, 0);

        // Restart during PLAY at cycle 9
        bus.start = 1'b1;
        run(1);
        run(8);
        chk_out("restart_pre", 5'd2, 2, 1, 1, 0);
        bus.start = 1'b1;
        run(1);
        chk_out("restart_c9", 5'd0, 0, 0, 1, 0);
        run(1);
        chk_out("restart_c10", 5'd0, 0, 0, 1, 0);
        run(2);
        chk_out("restart_c12", 5'd0, 0, 0, 1, 0);
        run(1);
        chk_out("restart_c13", 5'd1, 1, 1, 1, 0);

        // Write to the current step just before tick_hit presents old data
        bus.start = 1'b1;
        run(1);
        run(2);
        wr(0, 6'b011111);
        run(1);
        chk_out("late_write_old", 5'd1, 1, 1, 1, 0);
        bus.start = 1'b1;
        run(1);
        run(c_cpt);
        chk_out("late_write_new", 5'b11111, 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
